// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths, index/tag types and operand source encoding
package register_file_pkg;

  localparam int REG_WIDTH = 5;
  localparam int ROB_WIDTH = 4;
  localparam int ROB_SIZE  = 1 << ROB_WIDTH;
  localparam int NUM_REGS  = 1 << REG_WIDTH;
  localparam int XLEN      = 32;

  typedef logic [REG_WIDTH-1:0]         reg_idx_t;
  typedef logic [$clog2(ROB_SIZE)-1:0]  rob_id_t;
  typedef logic [XLEN-1:0]              word_t;

  // Where a resolved source operand comes from, in priority order.
  typedef enum logic [1:0] {
    SRC_ARCH   = 2'd0,
    SRC_COMMIT = 2'd1,
    SRC_ROB    = 2'd2,
    SRC_WAIT   = 2'd3
  } operand_src_e;

endpackage

// File: rtl/register_file_operand_resolve.sv
// rtl/register_file_operand_resolve.sv - per-source operand priority mux (arch, commit bypass, ROB, tag)
module register_file_operand_resolve
  import register_file_pkg::*;
(
  input  logic [REG_WIDTH-1:0] rs,
  input  logic                 busy,
  input  logic [ROB_WIDTH-1:0] tag,
  input  logic [XLEN-1:0]      arch_val,
  input  logic [REG_WIDTH-1:0] commit_reg_id,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [XLEN-1:0]      commit_data,
  input  logic                 rob_ready,
  input  logic [XLEN-1:0]      rob_data,
  output logic [XLEN-1:0]      val,
  output logic                 dep_valid,
  output logic [ROB_WIDTH-1:0] dep
);

  operand_src_e src;

  always_comb begin
    src = SRC_WAIT;
    if (rs == '0 || !busy) begin
      src = SRC_ARCH;
    end else if (commit_reg_id == rs && commit_rob_id == tag) begin
      src = SRC_COMMIT;
    end else if (rob_ready) begin
      src = SRC_ROB;
    end
  end

  always_comb begin
    val       = '0;
    dep_valid = 1'b0;
    dep       = tag;
    case (src)
      SRC_ARCH:   val = (rs == '0) ? '0 : arch_val;
      SRC_COMMIT: val = commit_data;
      SRC_ROB:    val = rob_data;
      default:    dep_valid = 1'b1;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with rename tags, commit bypass and flush
module register_file
  import register_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [REG_WIDTH-1:0] dec_rs1,
  input  logic [REG_WIDTH-1:0] dec_rs2,
  output logic [XLEN-1:0]      dec_val_j,
  output logic                 dec_dep_valid_j,
  output logic [ROB_WIDTH-1:0] dec_dep_j,
  output logic [XLEN-1:0]      dec_val_k,
  output logic                 dec_dep_valid_k,
  output logic [ROB_WIDTH-1:0] dec_dep_k,
  input  logic                 dec_rename_en,
  input  logic [REG_WIDTH-1:0] dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic [ROB_WIDTH-1:0] rob_query_j,
  output logic [ROB_WIDTH-1:0] rob_query_k,
  input  logic                 rob_ready_j,
  input  logic [XLEN-1:0]      rob_data_j,
  input  logic                 rob_ready_k,
  input  logic [XLEN-1:0]      rob_data_k,
  input  logic [REG_WIDTH-1:0] commit_reg_id,
  input  logic [XLEN-1:0]      commit_data,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic                 flush
);

  logic [XLEN-1:0]      val_q  [NUM_REGS];
  logic                 busy_q [NUM_REGS];
  logic [ROB_WIDTH-1:0] tag_q  [NUM_REGS];

  // Later assignments win: commit releases, flush clears, then rename re-claims.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_reg_id != '0) begin
        val_q[commit_reg_id] <= commit_data;
        if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id) begin
          busy_q[commit_reg_id] <= 1'b0;
        end
      end
      if (flush) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          busy_q[i] <= 1'b0;
        end
      end else if (dec_rename_en && dec_rd != '0) begin
        busy_q[dec_rd] <= 1'b1;
        tag_q[dec_rd]  <= dec_rob_id;
      end
    end
  end

  assign rob_query_j = tag_q[dec_rs1];
  assign rob_query_k = tag_q[dec_rs2];

  register_file_operand_resolve u_resolve_j (
    .rs            (dec_rs1),
    .busy          (busy_q[dec_rs1]),
    .tag           (tag_q[dec_rs1]),
    .arch_val      (val_q[dec_rs1]),
    .commit_reg_id (commit_reg_id),
    .commit_rob_id (commit_rob_id),
    .commit_data   (commit_data),
    .rob_ready     (rob_ready_j),
    .rob_data      (rob_data_j),
    .val           (dec_val_j),
    .dep_valid     (dec_dep_valid_j),
    .dep           (dec_dep_j)
  );

  register_file_operand_resolve u_resolve_k (
    .rs            (dec_rs2),
    .busy          (busy_q[dec_rs2]),
    .tag           (tag_q[dec_rs2]),
    .arch_val      (val_q[dec_rs2]),
    .commit_reg_id (commit_reg_id),
    .commit_rob_id (commit_rob_id),
    .commit_data   (commit_data),
    .rob_ready     (rob_ready_k),
    .rob_data      (rob_data_k),
    .val           (dec_val_k),
    .dep_valid     (dec_dep_valid_k),
    .dep           (dec_dep_k)
  );

endmodule
